// File: rtl/count_seq_checker_if.sv
// Bundles the observed counter bus, sample controls and monitor results between
// whatever drives the checker (master) and the checker itself (slave).
interface count_seq_checker_if #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
);
   logic             count_rst;
   logic [WIDTH-1:0] count_in;
   logic             en;
   logic             clr_stats;
   logic             locked;
   logic             err;
   logic             sticky_err;
   logic [ERR_W-1:0] err_cnt;
   logic [ERR_W-1:0] wrap_cnt;
   logic [WIDTH-1:0] exp_count;

   modport master (
      output count_rst, count_in, en, clr_stats,
      input  locked, err, sticky_err, err_cnt, wrap_cnt, exp_count
   );

   modport slave (
      input  count_rst, count_in, en, clr_stats,
      output locked, err, sticky_err, err_cnt, wrap_cnt, exp_count
   );
endinterface

// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running up-counter: tracks lock to the expected
// value, pulses err on every mismatch and keeps saturating error/wrap statistics.
module count_seq_checker #(
   parameter int WIDTH  = 4,
   parameter int ERR_W  = 8,
   parameter int RELOCK = 2
) (
   input logic                clk,
   input logic                rst,
   count_seq_checker_if.slave bus
);

   localparam logic [1:0] ST_RESET_WAIT = 2'd0;
   localparam logic [1:0] ST_LOCKED     = 2'd1;
   localparam logic [1:0] ST_RESYNC     = 2'd2;

   localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
   localparam logic [ERR_W-1:0] STAT_ONE   = ERR_W'(1);
   localparam logic [3:0]       RELOCK_RUN = 4'(RELOCK);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [3:0]       run_q, run_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic             wrap_hit;
   logic             match;

   // In RESET_WAIT exp_q is held at 0, so this also covers "first sample is 0".
   assign match = (bus.count_in == exp_q);

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d  = state_q;
      exp_d    = exp_q;
      run_d    = run_q;
      err_d    = 1'b0;
      wrap_hit = 1'b0;
      if (bus.en) begin
         if (bus.count_rst) begin
            state_d = ST_RESET_WAIT;
            exp_d   = '0;
            run_d   = '0;
         end else if (!match) begin
            err_d   = 1'b1;
            state_d = ST_RESYNC;
            exp_d   = bus.count_in + CNT_ONE;
            run_d   = '0;
         end else begin
            exp_d = exp_q + CNT_ONE;
            case (state_q)
               ST_RESET_WAIT: state_d = ST_LOCKED;
               ST_LOCKED:     wrap_hit = (bus.count_in == '0);
               ST_RESYNC: begin
                  if (run_q + 4'd1 >= RELOCK_RUN) begin
                     state_d = ST_LOCKED;
                     run_d   = '0;
                  end else begin
                     run_d = run_q + 4'd1;
                  end
               end
               default: begin
                  state_d = ST_RESET_WAIT;
                  exp_d   = '0;
                  run_d   = '0;
               end
            endcase
         end
      end
   end

   // Clearing takes precedence over any increment in the same cycle.
   always_comb begin
      sticky_d   = sticky_q;
      err_cnt_d  = err_cnt_q;
      wrap_cnt_d = wrap_cnt_q;
      if (bus.clr_stats) begin
         sticky_d   = 1'b0;
         err_cnt_d  = '0;
         wrap_cnt_d = '0;
      end else begin
         if (err_d) begin
            sticky_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + STAT_ONE;
         end
         if (wrap_hit && wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + STAT_ONE;
      end
   end

   assign locked_d = (state_d == ST_LOCKED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RESET_WAIT;
         exp_q      <= '0;
         run_q      <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         sticky_q   <= 1'b0;
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         exp_q      <= exp_d;
         run_q      <= run_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         sticky_q   <= sticky_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.err        = err_q;
   assign bus.sticky_err = sticky_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.wrap_cnt   = wrap_cnt_q;
   assign bus.exp_count  = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: a vector table for the main sequences,
// then hand-written clear/saturation and asynchronous reset sequences.
module tb_count_seq_checker;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   count_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();

   count_seq_checker #(.WIDTH(4), .ERR_W(8), .RELOCK(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       crst;
      logic [3:0] cin;
      logic       clr;
      logic       locked;
      logic       err;
      logic       sticky;
      logic [7:0] ec;
      logic [7:0] wc;
      logic [3:0] expc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic en, input logic crst, input logic [3:0] cin,
                               input logic clr, input logic locked, input logic err,
                               input logic sticky, input logic [7:0] ec,
                               input logic [7:0] wc, input logic [3:0] expc);
      vec_t v;
      v.en = en; v.crst = crst; v.cin = cin; v.clr = clr;
      v.locked = locked; v.err = err; v.sticky = sticky;
      v.ec = ec; v.wc = wc; v.expc = expc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic step(input logic en, input logic crst, input logic [3:0] cin, input logic clr);
      bus.en        = en;
      bus.count_rst = crst;
      bus.count_in  = cin;
      bus.clr_stats = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic locked, input logic err,
                            input logic sticky, input logic [7:0] ec, input logic [7:0] wc,
                            input logic [3:0] expc);
      check({tag, ".locked"},     32'(bus.locked),     32'(locked));
      check({tag, ".err"},        32'(bus.err),        32'(err));
      check({tag, ".sticky_err"}, 32'(bus.sticky_err), 32'(sticky));
      check({tag, ".err_cnt"},    32'(bus.err_cnt),    32'(ec));
      check({tag, ".wrap_cnt"},   32'(bus.wrap_cnt),   32'(wc));
      check({tag, ".exp_count"},  32'(bus.exp_count),  32'(expc));
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      bus.en        = 1'b0;
      bus.count_rst = 1'b0;
      bus.count_in  = '0;
      bus.clr_stats = 1'b0;
      rst           = 1'b1;
      #2 rst = 1'b0;
      #1 check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1: counter reset, full wrap, then 0..3 again
      vecs.push_back(mk(1, 1, 4'd5, 0, 0, 0, 0, 8'd0, 8'd0, 4'd0));
      for (int i = 0; i < 20; i++)
         vecs.push_back(mk(1, 0, 4'(i % 16), 0, 1, 0, 0, 8'd0,
                           (i >= 16) ? 8'd1 : 8'd0, 4'((i + 1) % 16)));
      // 2: skip 6, RESYNC, relock after two good samples
      vecs.push_back(mk(1, 0, 4'd4, 0, 1, 0, 0, 8'd0, 8'd1, 4'd5));
      vecs.push_back(mk(1, 0, 4'd5, 0, 1, 0, 0, 8'd0, 8'd1, 4'd6));
      vecs.push_back(mk(1, 0, 4'd7, 0, 0, 1, 1, 8'd1, 8'd1, 4'd8));
      vecs.push_back(mk(1, 0, 4'd8, 0, 0, 0, 1, 8'd1, 8'd1, 4'd9));
      vecs.push_back(mk(1, 0, 4'd9, 0, 1, 0, 1, 8'd1, 8'd1, 4'd10));
      // 3: counter reset mid-stream; its 0 sample is not a wrap
      vecs.push_back(mk(1, 1, 4'd10, 0, 0, 0, 1, 8'd1, 8'd1, 4'd0));
      vecs.push_back(mk(1, 0, 4'd0, 0, 1, 0, 1, 8'd1, 8'd1, 4'd1));
      vecs.push_back(mk(1, 0, 4'd1, 0, 1, 0, 1, 8'd1, 8'd1, 4'd2));
      vecs.push_back(mk(1, 0, 4'd2, 0, 1, 0, 1, 8'd1, 8'd1, 4'd3));
      // 4: first sample after counter reset is non-zero
      vecs.push_back(mk(1, 1, 4'd9, 0, 0, 0, 1, 8'd1, 8'd1, 4'd0));
      vecs.push_back(mk(1, 0, 4'd3, 0, 0, 1, 1, 8'd2, 8'd1, 4'd4));
      vecs.push_back(mk(1, 0, 4'd4, 0, 0, 0, 1, 8'd2, 8'd1, 4'd5));
      vecs.push_back(mk(1, 0, 4'd5, 0, 1, 0, 1, 8'd2, 8'd1, 4'd6));
      // 5: en low with random bus contents, then resume
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 1'($urandom_range(1)), 4'($urandom_range(15)), 0,
                           1, 0, 1, 8'd2, 8'd1, 4'd6));
      vecs.push_back(mk(1, 0, 4'd6, 0, 1, 0, 1, 8'd2, 8'd1, 4'd7));
      vecs.push_back(mk(1, 0, 4'd7, 0, 1, 0, 1, 8'd2, 8'd1, 4'd8));

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].crst, vecs[i].cin, vecs[i].clr);
         check_all($sformatf("row%0d", i), vecs[i].locked, vecs[i].err, vecs[i].sticky,
                   vecs[i].ec, vecs[i].wc, vecs[i].expc);
      end

      // 6: mismatch together with clr_stats: pulse fires, statistics cleared
      step(1, 0, 4'd12, 1);
      check_all("clr_err", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 4'd13);

      // 300 mismatches: count_in stuck at 5 never equals exp_count=6
      for (int i = 1; i <= 300; i++) begin
         step(1, 0, 4'd5, 0);
         if (i == 254) check("sat.err_cnt_254", 32'(bus.err_cnt), 32'd254);
         if (i == 255) check("sat.err_cnt_255", 32'(bus.err_cnt), 32'd255);
      end
      check_all("sat_end", 1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 4'd6);

      // asynchronous reset between clock edges
      #2 rst = 1'b0;
      #1 check_all("async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
      bus.en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
